pic_isr_ctrl: RTL and testbench

- Parametrised, clocked in-service register (ISR) controller for the PIC: N interrupt levels instead of a fixed 8.
- Runs the two-pulse INTA acknowledge sequence and supports non-specific, specific and automatic EOI.
- Adds rotating priority: automatic rotation and specific set-priority.
- Sits between the priority resolver (supplies the grant; consumes the highest in-service level for masking) and the vector/data-bus logic.

---
 rtl/pic_pkg.sv | 35 +++
 rtl/pic_rot_prio_sel.sv | 32 +++
 rtl/pic_isr_ctrl.sv | 153 +++++++++++++++
 tb/tb_pic_isr_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC in-service/priority logic.
// Level helpers work on vectors up to MAX_N wide, so N must not exceed MAX_N.
package pic_pkg;

    localparam int MAX_N = 64;
    localparam int MAX_L = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } pic_state_e;

    // Level reported for an acknowledge with no winning request.
    function automatic int spurious_level(input int n);
        return n - 1;
    endfunction

    // Lowest set index wins, so an illegal multi-hot input still encodes deterministically.
    function automatic int onehot_to_level(input logic [MAX_N-1:0] v);
        int lvl;
        lvl = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (v[i[MAX_L-1:0]]) begin
                lvl = i;
            end
        end
        return lvl;
    endfunction

    // Wrap is an explicit compare so non-power-of-two N behaves.
    function automatic int level_wrap_inc(input int lvl, input int n);
        return (lvl >= n - 1) ? 0 : lvl + 1;
    endfunction

endpackage

// File: rtl/pic_rot_prio_sel.sv
// Rotating-priority selector: returns the one-hot highest-priority set bit of req,
// where the level after lowest_level (cyclically) has the highest priority.
module pic_rot_prio_sel
    import pic_pkg::*;
#(
    parameter int N = 8,
    parameter int L = $clog2(N)
) (
    input  logic [L-1:0] lowest_level,
    input  logic [N-1:0] req,
    output logic [N-1:0] highest
);

    int           top_lvl;
    logic [L-1:0] rank [N];

    assign top_lvl = level_wrap_inc(int'(lowest_level), N);

    // rank 0 is the highest priority level
    for (genvar gi = 0; gi < N; gi++) begin : g_rank
        assign rank[gi] = (gi >= top_lvl) ? L'(gi - top_lvl) : L'(gi + N - top_lvl);
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_win
        logic [N-1:0] beats;
        for (genvar gj = 0; gj < N; gj++) begin : g_cmp
            assign beats[gj] = req[gj] && (rank[gj] < rank[gi]);
        end
        assign highest[gi] = req[gi] && !(|beats);
    end

endmodule

// File: rtl/pic_isr_ctrl.sv
// In-service register controller: two-pulse INTA sequencing, EOI handling
// (non-specific, specific, automatic) and rotating priority for N levels.
module pic_isr_ctrl
    import pic_pkg::*;
#(
    parameter int N = 8,
    parameter int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inta_strobe,
    input  logic [N-1:0] irq_grant,
    input  logic         aeoi_mode,
    input  logic         rotate_on_aeoi,
    input  logic         eoi_ns,
    input  logic         eoi_sp,
    input  logic [L-1:0] eoi_level,
    input  logic         eoi_rotate,
    input  logic         set_prio,
    input  logic [L-1:0] set_prio_level,
    output logic [N-1:0] isr,
    output logic [N-1:0] highest_isr,
    output logic [L-1:0] lowest_level,
    output logic [N-1:0] irr_clear,
    output logic         vector_valid,
    output logic [L-1:0] vector_level,
    output logic         spurious
);

    localparam logic [L-1:0] SPUR_LVL = L'(spurious_level(N));

    pic_state_e   state_q, state_d;
    logic [L-1:0] lat_lvl_q, lat_lvl_d;
    logic         lat_sp_q, lat_sp_d;
    logic [N-1:0] isr_q, isr_d;
    logic [N-1:0] irr_clear_q, irr_clear_d;
    logic [L-1:0] lowest_q, lowest_d;
    logic         vec_vld_q, vec_vld_d;
    logic [L-1:0] vec_lvl_q, vec_lvl_d;
    logic         spur_q, spur_d;

    logic [N-1:0] set_mask, clr_mask;
    logic [L-1:0] grant_lvl, hi_lvl;
    logic         eoi_sp_ok, set_prio_ok;

    pic_rot_prio_sel #(.N(N), .L(L)) u_sel (
        .lowest_level (lowest_q),
        .req          (isr_q),
        .highest      (highest_isr)
    );

    assign grant_lvl   = L'(onehot_to_level(MAX_N'(irq_grant)));
    assign hi_lvl      = L'(onehot_to_level(MAX_N'(highest_isr)));
    assign eoi_sp_ok   = eoi_sp && (int'(eoi_level) < N);
    assign set_prio_ok = set_prio && (int'(set_prio_level) < N);

    always_comb begin
        state_d     = state_q;
        lat_lvl_d   = lat_lvl_q;
        lat_sp_d    = lat_sp_q;
        irr_clear_d = '0;
        vec_vld_d   = 1'b0;
        vec_lvl_d   = vec_lvl_q;
        spur_d      = 1'b0;
        set_mask    = '0;
        clr_mask    = '0;
        lowest_d    = lowest_q;

        // Rotation sources are applied lowest-precedence first so later ones override.
        if (set_prio_ok) begin
            lowest_d = set_prio_level;
        end

        case (state_q)
            IDLE: begin
                if (inta_strobe) begin
                    state_d = WAIT2;
                    if (|irq_grant) begin
                        lat_lvl_d   = grant_lvl;
                        lat_sp_d    = 1'b0;
                        set_mask    = N'(1) << grant_lvl;
                        irr_clear_d = set_mask;
                    end else begin
                        lat_lvl_d = SPUR_LVL;
                        lat_sp_d  = 1'b1;
                    end
                end
            end
            WAIT2: begin
                if (inta_strobe) begin
                    state_d   = IDLE;
                    vec_vld_d = 1'b1;
                    vec_lvl_d = lat_lvl_q;
                    spur_d    = lat_sp_q;
                    if (aeoi_mode && !lat_sp_q) begin
                        clr_mask = N'(1) << lat_lvl_q;
                        if (rotate_on_aeoi) begin
                            lowest_d = lat_lvl_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (eoi_sp_ok) begin
            clr_mask = clr_mask | (N'(1) << eoi_level);
            if (eoi_rotate) begin
                lowest_d = eoi_level;
            end
        end else if (eoi_ns && (|isr_q)) begin
            clr_mask = clr_mask | highest_isr;
            if (eoi_rotate) begin
                lowest_d = hi_lvl;
            end
        end

        // A same-cycle INTA set of a bit wins over any clear of it.
        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_lvl_q   <= '0;
            lat_sp_q    <= 1'b0;
            isr_q       <= '0;
            irr_clear_q <= '0;
            lowest_q    <= SPUR_LVL;
            vec_vld_q   <= 1'b0;
            vec_lvl_q   <= '0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_lvl_q   <= lat_lvl_d;
            lat_sp_q    <= lat_sp_d;
            isr_q       <= isr_d;
            irr_clear_q <= irr_clear_d;
            lowest_q    <= lowest_d;
            vec_vld_q   <= vec_vld_d;
            vec_lvl_q   <= vec_lvl_d;
            spur_q      <= spur_d;
        end
    end

    assign isr          = isr_q;
    assign lowest_level = lowest_q;
    assign irr_clear    = irr_clear_q;
    assign vector_valid = vec_vld_q;
    assign vector_level = vec_lvl_q;
    assign spurious     = spur_q;

endmodule

// File: tb/tb_pic_isr_ctrl.sv
// Directed bench for pic_isr_ctrl (N=8 and N=5 instances); irr_clear and vector
// pulses are checked by a monitor against queues filled by the stimulus.
module tb_pic_isr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel_b = 1'b0;
    logic       inta = 1'b0, eoi_ns = 1'b0, eoi_sp = 1'b0, eoi_rotate = 1'b0;
    logic       set_prio = 1'b0, aeoi_mode = 1'b0, rotate_on_aeoi = 1'b0;
    logic [7:0] grant = 8'h00;
    logic [2:0] eoi_level = 3'd0, set_prio_level = 3'd0;

    logic a_inta, a_ns, a_sp, a_prio, b_inta, b_ns, b_sp, b_prio;
    assign a_inta = inta & ~sel_b;
    assign a_ns   = eoi_ns & ~sel_b;
    assign a_sp   = eoi_sp & ~sel_b;
    assign a_prio = set_prio & ~sel_b;
    assign b_inta = inta & sel_b;
    assign b_ns   = eoi_ns & sel_b;
    assign b_sp   = eoi_sp & sel_b;
    assign b_prio = set_prio & sel_b;

    logic [7:0] a_isr, a_hi, a_irr;
    logic [2:0] a_low, a_vl;
    logic       a_vv, a_spur;
    logic [4:0] b_isr, b_hi, b_irr;
    logic [2:0] b_low, b_vl;
    logic       b_vv, b_spur;

    pic_isr_ctrl #(.N(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .inta_strobe(a_inta), .irq_grant(grant),
        .aeoi_mode(aeoi_mode), .rotate_on_aeoi(rotate_on_aeoi),
        .eoi_ns(a_ns), .eoi_sp(a_sp), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
        .set_prio(a_prio), .set_prio_level(set_prio_level),
        .isr(a_isr), .highest_isr(a_hi), .lowest_level(a_low), .irr_clear(a_irr),
        .vector_valid(a_vv), .vector_level(a_vl), .spurious(a_spur)
    );

    pic_isr_ctrl #(.N(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .inta_strobe(b_inta), .irq_grant(grant[4:0]),
        .aeoi_mode(aeoi_mode), .rotate_on_aeoi(rotate_on_aeoi),
        .eoi_ns(b_ns), .eoi_sp(b_sp), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
        .set_prio(b_prio), .set_prio_level(set_prio_level),
        .isr(b_isr), .highest_isr(b_hi), .lowest_level(b_low), .irr_clear(b_irr),
        .vector_valid(b_vv), .vector_level(b_vl), .spurious(b_spur)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_irr_a[$];
    logic [3:0] exp_vec_a[$];   // {spurious, level}
    logic [4:0] exp_irr_b[$];
    logic [3:0] exp_vec_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, expected no pulse", name, act);
    endtask

    always @(negedge clk) begin
        if (a_irr !== 8'h00) begin
            if (exp_irr_a.size() == 0) unexpected("a_irr_clear", 32'(a_irr));
            else check("a_irr_clear", 32'(a_irr), 32'(exp_irr_a.pop_front()));
        end
        if (a_vv !== 1'b0) begin
            if (exp_vec_a.size() == 0) unexpected("a_vector", 32'({a_spur, a_vl}));
            else check("a_vector", 32'({a_spur, a_vl}), 32'(exp_vec_a.pop_front()));
        end
        if (b_irr !== 5'h00) begin
            if (exp_irr_b.size() == 0) unexpected("b_irr_clear", 32'(b_irr));
            else check("b_irr_clear", 32'(b_irr), 32'(exp_irr_b.pop_front()));
        end
        if (b_vv !== 1'b0) begin
            if (exp_vec_b.size() == 0) unexpected("b_vector", 32'({b_spur, b_vl}));
            else check("b_vector", 32'({b_spur, b_vl}), 32'(exp_vec_b.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_inta(input logic [7:0] g);
        grant = g;
        inta  = 1'b1;
        tick();
        inta  = 1'b0;
    endtask

    task automatic do_ns(input logic rot);
        eoi_ns     = 1'b1;
        eoi_rotate = rot;
        tick();
        eoi_ns     = 1'b0;
        eoi_rotate = 1'b0;
    endtask

    task automatic do_sp(input logic [2:0] lvl, input logic rot);
        eoi_sp     = 1'b1;
        eoi_level  = lvl;
        eoi_rotate = rot;
        tick();
        eoi_sp     = 1'b0;
        eoi_rotate = 1'b0;
    endtask

    task automatic do_prio(input logic [2:0] lvl);
        set_prio       = 1'b1;
        set_prio_level = lvl;
        tick();
        set_prio       = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_a_isr", 32'(a_isr), 32'h00);
        check("rst_a_lowest", 32'(a_low), 32'd7);
        check("rst_a_vv", 32'(a_vv), 32'd0);
        check("rst_a_irr", 32'(a_irr), 32'h00);
        check("rst_b_lowest", 32'(b_low), 32'd4);
        rst_n = 1'b1;
        tick();

        // basic two-pulse acknowledge of level 2
        exp_irr_a.push_back(8'h04);
        do_inta(8'h04);
        check("inta1_isr", 32'(a_isr), 32'h04);
        tick();
        exp_vec_a.push_back({1'b0, 3'd2});
        do_inta(8'h04);
        tick();
        check("inta2_isr", 32'(a_isr), 32'h04);

        // non-specific EOI order
        exp_irr_a.push_back(8'h10);
        do_inta(8'h10);
        exp_vec_a.push_back({1'b0, 3'd4});
        do_inta(8'h10);
        check("isr_14", 32'(a_isr), 32'h14);
        check("highest_14", 32'(a_hi), 32'h04);
        do_ns(1'b0);
        check("ns1_isr", 32'(a_isr), 32'h10);
        do_ns(1'b0);
        check("ns2_isr", 32'(a_isr), 32'h00);
        do_ns(1'b1);
        check("ns_empty_isr", 32'(a_isr), 32'h00);
        check("ns_empty_lowest", 32'(a_low), 32'd7);

        // AEOI with rotation
        aeoi_mode      = 1'b1;
        rotate_on_aeoi = 1'b1;
        exp_irr_a.push_back(8'h20);
        do_inta(8'h20);
        check("aeoi_inta1_isr", 32'(a_isr), 32'h20);
        exp_vec_a.push_back({1'b0, 3'd5});
        do_inta(8'h20);
        check("aeoi_isr", 32'(a_isr), 32'h00);
        check("aeoi_lowest", 32'(a_low), 32'd5);
        aeoi_mode      = 1'b0;
        rotate_on_aeoi = 1'b0;
        exp_irr_a.push_back(8'h01);
        do_inta(8'h01);
        exp_vec_a.push_back({1'b0, 3'd0});
        do_inta(8'h01);
        exp_irr_a.push_back(8'h40);
        do_inta(8'h40);
        exp_vec_a.push_back({1'b0, 3'd6});
        do_inta(8'h40);
        check("rot_isr_41", 32'(a_isr), 32'h41);
        check("rot_highest", 32'(a_hi), 32'h40);
        do_ns(1'b0);
        check("rot_ns_isr", 32'(a_isr), 32'h01);
        do_ns(1'b0);
        do_prio(3'd7);
        check("prio7_lowest", 32'(a_low), 32'd7);

        // spurious acknowledge
        exp_vec_a.push_back({1'b1, 3'd7});
        do_inta(8'h00);
        check("spur1_isr", 32'(a_isr), 32'h00);
        do_inta(8'h00);
        check("spur2_isr", 32'(a_isr), 32'h00);

        // simultaneous INTA set, specific EOI and dropped non-specific EOI
        exp_irr_a.push_back(8'h02);
        do_inta(8'h02);
        exp_vec_a.push_back({1'b0, 3'd1});
        do_inta(8'h02);
        exp_irr_a.push_back(8'h08);
        do_inta(8'h08);
        exp_vec_a.push_back({1'b0, 3'd3});
        do_inta(8'h08);
        check("pre_combo_isr", 32'(a_isr), 32'h0A);
        grant     = 8'h08;
        inta      = 1'b1;
        eoi_sp    = 1'b1;
        eoi_level = 3'd3;
        eoi_ns    = 1'b1;
        exp_irr_a.push_back(8'h08);
        tick();
        inta   = 1'b0;
        eoi_sp = 1'b0;
        eoi_ns = 1'b0;
        check("combo_isr", 32'(a_isr), 32'h0A);
        exp_vec_a.push_back({1'b0, 3'd3});
        do_inta(8'h08);
        do_sp(3'd1, 1'b1);
        check("sp_rot_isr", 32'(a_isr), 32'h08);
        check("sp_rot_lowest", 32'(a_low), 32'd1);
        do_sp(3'd3, 1'b0);
        check("sp_isr", 32'(a_isr), 32'h00);
        do_prio(3'd7);

        // reset while waiting for the second INTA
        exp_irr_a.push_back(8'h04);
        do_inta(8'h04);
        check("wait2_isr", 32'(a_isr), 32'h04);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstw_isr", 32'(a_isr), 32'h00);
        check("rstw_vv", 32'(a_vv), 32'd0);
        check("rstw_vec", 32'({a_spur, a_vl}), 32'h0);
        check("rstw_irr", 32'(a_irr), 32'h00);
        check("rstw_lowest", 32'(a_low), 32'd7);
        tick();
        rst_n = 1'b1;
        tick();
        exp_irr_a.push_back(8'h02);
        do_inta(8'h02);
        check("post_rst_isr", 32'(a_isr), 32'h02);
        exp_vec_a.push_back({1'b0, 3'd1});
        do_inta(8'h02);
        do_sp(3'd1, 1'b0);

        // N=5 instance: set-priority range and wrap
        sel_b = 1'b1;
        do_prio(3'd2);
        check("b_prio2", 32'(b_low), 32'd2);
        do_prio(3'd4);
        check("b_prio4", 32'(b_low), 32'd4);
        do_prio(3'd7);
        check("b_prio7_ignored", 32'(b_low), 32'd4);
        exp_irr_b.push_back(5'h10);
        do_inta(8'h10);
        exp_vec_b.push_back({1'b0, 3'd4});
        do_inta(8'h10);
        exp_irr_b.push_back(5'h01);
        do_inta(8'h01);
        exp_vec_b.push_back({1'b0, 3'd0});
        do_inta(8'h01);
        check("b_isr_11", 32'(b_isr), 32'h11);
        check("b_wrap_highest", 32'(b_hi), 32'h01);
        do_sp(3'd7, 1'b1);
        check("b_sp_oob_isr", 32'(b_isr), 32'h11);
        check("b_sp_oob_lowest", 32'(b_low), 32'd4);
        do_sp(3'd4, 1'b1);
        check("b_sp4_isr", 32'(b_isr), 32'h01);
        do_ns(1'b1);
        check("b_ns_rot_isr", 32'(b_isr), 32'h00);
        check("b_ns_rot_lowest", 32'(b_low), 32'd0);
        exp_vec_b.push_back({1'b1, 3'd4});
        do_inta(8'h00);
        do_inta(8'h00);
        sel_b = 1'b0;

        repeat (3) tick();
        check("queues_drained",
              32'(exp_irr_a.size() + exp_vec_a.size() + exp_irr_b.size() + exp_vec_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
